// File: rtl/imem_loader_if.sv
// Write port from the program loader into instr_mem.
// Ports (via modports):
//   master - driven by imem_loader: wr_en, wr_addr, wr_data
//   slave  - consumed by instr_mem:  wr_en, wr_addr, wr_data
interface imem_loader_if #(
   parameter int ADDR_W = 7
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/imem_loader.sv
// Keys a program into instr_mem one hex nibble at a time. Eight nibbles
// (MSB first) form a 32-bit word, which is written with a one-cycle strobe
// at the next word address. The CPU is held in reset for the whole session.
//
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   load_en             - level, requests a load session
//   nibble              - hex digit to append
//   key_nibble          - debounced level, rising edge appends nibble
//   key_finish          - debounced level, rising edge ends the session
//   imem (master)       - wr_en / wr_addr / wr_data to instr_mem
//   cpu_hold            - high whenever not IDLE
//   preview             - current shift register
//   nib_cnt             - nibbles entered in the current word
//   word_cnt            - words written this session
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no session; CPU runs; waits for load_en
// ENTRY | collecting nibbles into the shift register
// WRITE | single cycle; wr_en high, word written, counters advance
// DONE  | session ended (finish key or MAX_WORDS); waits for load_en=0
module imem_loader #(
   parameter int ADDR_W    = 7,
   parameter int MAX_WORDS = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load_en,
   input  logic [3:0]          nibble,
   input  logic                key_nibble,
   input  logic                key_finish,
   imem_loader_if.master       imem,
   output logic                cpu_hold,
   output logic [31:0]         preview,
   output logic [2:0]          nib_cnt,
   output logic [ADDR_W-2:0]   word_cnt
);

   typedef enum logic [1:0] {IDLE, ENTRY, WRITE, DONE} state_t;

   localparam logic [ADDR_W-2:0] LAST_CNT = (ADDR_W-1)'(MAX_WORDS - 1);

   state_t              state, state_nxt;
   logic [31:0]         shift;
   logic [31:0]         shift_nxt;
   logic [ADDR_W-3:0]   word_idx;
   logic                key_nibble_q, key_finish_q;
   logic                nib_edge, fin_edge;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [31:0]         wr_data_q;

   logic                start;
   logic                discard;
   logic                shift_en;
   logic                commit;

   // Edge registers reset high so a key held through reset is not counted.
   assign nib_edge  = key_nibble & ~key_nibble_q;
   assign fin_edge  = key_finish & ~key_finish_q;
   assign shift_nxt = {shift[27:0], nibble};

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      discard   = 1'b0;
      shift_en  = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (load_en) begin
               state_nxt = ENTRY;
               start     = 1'b1;
            end
         end
         ENTRY: begin
            if (!load_en) begin
               state_nxt = IDLE;
               discard   = 1'b1;
            end else if (fin_edge) begin
               state_nxt = DONE;
            end else if (nib_edge) begin
               shift_en = 1'b1;
               if (nib_cnt == 3'd7) begin
                  state_nxt = WRITE;
               end
            end
         end
         WRITE: begin
            // The write always completes; load_en only picks the exit.
            commit = 1'b1;
            if (word_cnt == LAST_CNT) begin
               state_nxt = DONE;
            end else if (load_en) begin
               state_nxt = ENTRY;
            end else begin
               state_nxt = IDLE;
            end
         end
         DONE: begin
            if (!load_en) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         key_nibble_q <= 1'b1;
         key_finish_q <= 1'b1;
         shift        <= '0;
         nib_cnt      <= '0;
         word_idx     <= '0;
         word_cnt     <= '0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
      end else begin
         key_nibble_q <= key_nibble;
         key_finish_q <= key_finish;
         if (start) begin
            shift    <= '0;
            nib_cnt  <= '0;
            word_idx <= '0;
            word_cnt <= '0;
         end else if (discard) begin
            shift   <= '0;
            nib_cnt <= '0;
         end else if (shift_en) begin
            shift   <= shift_nxt;
            nib_cnt <= nib_cnt + 3'd1;
            // Capture the completed word so wr_data/wr_addr are registered
            // and stable during the WRITE cycle.
            if (nib_cnt == 3'd7) begin
               wr_data_q <= shift_nxt;
               wr_addr_q <= {word_idx, 2'b00};
            end
         end else if (commit) begin
            shift    <= '0;
            word_idx <= word_idx + 1'b1;
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

   assign imem.wr_en   = (state == WRITE);
   assign imem.wr_addr = wr_addr_q;
   assign imem.wr_data = wr_data_q;
   assign cpu_hold     = (state != IDLE);
   assign preview      = shift;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

   localparam int ADDR_W    = 7;
   localparam int MAX_WORDS = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              load_en = 1'b0;
   logic [3:0]        nibble = 4'h0;
   logic              key_nibble = 1'b0;
   logic              key_finish = 1'b0;
   logic              cpu_hold;
   logic [31:0]       preview;
   logic [2:0]        nib_cnt;
   logic [ADDR_W-2:0] word_cnt;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_en    (load_en),
      .nibble     (nibble),
      .key_nibble (key_nibble),
      .key_finish (key_finish),
      .imem       (bus),
      .cpu_hold   (cpu_hold),
      .preview    (preview),
      .nib_cnt    (nib_cnt),
      .word_cnt   (word_cnt)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Reference model: session-level view of the loader.
   bit          m_active = 0;
   bit          m_done   = 0;
   int          m_nib    = 0;
   int          m_words  = 0;
   logic [31:0] m_shift  = '0;
   int          exp_writes = 0;
   logic [31:0] exp_data_q[$];
   int          exp_addr_q[$];

   int          act_writes = 0;
   logic [31:0] last_data  = '0;
   logic [31:0] last_addr  = '0;

   always @(negedge clock) begin
      if (bus.wr_en === 1'b1) begin
         act_writes++;
         last_data = bus.wr_data;
         last_addr = 32'(bus.wr_addr);
         if (exp_data_q.size() == 0) begin
            chk("unexpected_wr", 32'(bus.wr_en), 32'd0);
         end else begin
            chk("wr_data", bus.wr_data, exp_data_q.pop_front());
            chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr_q.pop_front()));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_hold"}, 32'(cpu_hold), 32'(m_active));
      chk({tag, "_wcnt"}, 32'(word_cnt), 32'(m_words));
      if (m_active) chk({tag, "_ncnt"}, 32'(nib_cnt), 32'(m_nib));
      if (m_active && !m_done) chk({tag, "_prev"}, preview, m_shift);
   endtask

   task automatic model_start();
      m_active = 1; m_done = 0; m_nib = 0; m_words = 0; m_shift = '0;
   endtask

   task automatic press(input logic [3:0] n, input bit chk_it);
      if (m_active && !m_done) begin
         m_shift = {m_shift[27:0], n};
         m_nib++;
         if (m_nib == 8) begin
            exp_data_q.push_back(m_shift);
            exp_addr_q.push_back(m_words * 4);
            exp_writes++;
            m_words++;
            m_nib = 0;
            m_shift = '0;
            if (m_words == MAX_WORDS) m_done = 1;
         end
      end
      nibble = n;
      key_nibble = 1'b1;
      tick(2);
      key_nibble = 1'b0;
      tick(2);
      if (chk_it) check_state("press");
   endtask

   task automatic finish();
      if (m_active && !m_done) m_done = 1;
      key_finish = 1'b1;
      tick(2);
      key_finish = 1'b0;
      tick(2);
      check_state("finish");
   endtask

   task automatic set_load(input logic v);
      if (v && !m_active) model_start();
      if (!v && m_active) begin
         if (!m_done) begin
            m_nib = 0;
            m_shift = '0;
         end
         m_active = 0;
         m_done = 0;
      end
      load_en = v;
      tick(1);
      chk("load_hold", 32'(cpu_hold), 32'(m_active));
      tick(1);
      check_state("load");
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1);
      chk("rst_wr_en",  32'(bus.wr_en), 32'd0);
      chk("rst_addr",   32'(bus.wr_addr), 32'd0);
      chk("rst_data",   bus.wr_data, 32'd0);
      chk("rst_prev",   preview, 32'd0);
      chk("rst_ncnt",   32'(nib_cnt), 32'd0);
      chk("rst_wcnt",   32'(word_cnt), 32'd0);
      chk("rst_hold",   32'(cpu_hold), 32'd0);
      m_active = 0; m_done = 0; m_nib = 0; m_words = 0; m_shift = '0;
      tick(1);
      reset = 1'b0;
      if (load_en) model_start();
      tick(2);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      logic [3:0] t2 [8];
      t2 = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h9};

      tick(1);
      do_reset();

      // 1: first word
      set_load(1'b1);
      w0 = act_writes;
      for (int i = 1; i <= 8; i++) press(4'(i), 1'b1);
      chk("t1_nwr",  32'(act_writes - w0), 32'd1);
      chk("t1_data", last_data, 32'h12345678);
      chk("t1_addr", last_addr, 32'h00);
      chk("t1_wcnt", 32'(word_cnt), 32'd1);

      // 2: second word
      for (int i = 0; i < 8; i++) press(t2[i], 1'b1);
      chk("t2_data", last_data, 32'hABCDEF09);
      chk("t2_addr", last_addr, 32'h04);
      chk("t2_wcnt", 32'(word_cnt), 32'd2);
      chk("t2_ncnt", 32'(nib_cnt), 32'd0);

      // 3: fill a fresh session to MAX_WORDS
      set_load(1'b0);
      set_load(1'b1);
      w0 = act_writes;
      for (int w = 0; w < MAX_WORDS; w++)
         for (int i = 0; i < 8; i++) press(4'($urandom_range(0, 15)), i == 7);
      chk("t3_nwr",  32'(act_writes - w0), 32'(MAX_WORDS));
      chk("t3_last", last_addr, 32'h7C);
      chk("t3_wcnt", 32'(word_cnt), 32'(MAX_WORDS));
      w0 = act_writes;
      for (int i = 0; i < 9; i++) press(4'($urandom_range(0, 15)), 1'b0);
      chk("t3_nowr", 32'(act_writes - w0), 32'd0);
      chk("t3_done_hold", 32'(cpu_hold), 32'd1);
      set_load(1'b0);

      // 4: abandon a partial word
      set_load(1'b1);
      w0 = act_writes;
      for (int i = 0; i < 5; i++) press(4'($urandom_range(0, 15)), 1'b1);
      set_load(1'b0);
      chk("t4_nwr",  32'(act_writes - w0), 32'd0);
      chk("t4_ncnt", 32'(nib_cnt), 32'd0);
      set_load(1'b1);
      chk("t4_wcnt", 32'(word_cnt), 32'd0);
      for (int i = 0; i < 8; i++) press(4'($urandom_range(0, 15)), 1'b1);
      chk("t4_addr", last_addr, 32'h00);

      // 5: key held across reset, then simultaneous nibble+finish edges
      key_nibble = 1'b1;
      do_reset();
      tick(4);
      chk("t5_held", 32'(nib_cnt), 32'd0);
      key_nibble = 1'b0;
      tick(2);
      for (int i = 0; i < 3; i++) press(4'($urandom_range(0, 15)), 1'b1);
      w0 = act_writes;
      m_done = 1;
      nibble = 4'h5;
      key_nibble = 1'b1;
      key_finish = 1'b1;
      tick(2);
      key_nibble = 1'b0;
      key_finish = 1'b0;
      tick(2);
      chk("t5_ncnt", 32'(nib_cnt), 32'd3);
      chk("t5_hold", 32'(cpu_hold), 32'd1);
      press(4'h7, 1'b1);
      chk("t5_nwr", 32'(act_writes - w0), 32'd0);
      set_load(1'b0);

      // 6: reset lands on the edge that would enter WRITE
      set_load(1'b1);
      for (int i = 0; i < 7; i++) press(4'($urandom_range(0, 15)), 1'b1);
      w0 = act_writes;
      nibble = 4'hC;
      key_nibble = 1'b1;
      do_reset();
      chk("t6_nwr", 32'(act_writes - w0), 32'd0);
      key_nibble = 1'b0;
      tick(2);
      check_state("t6");

      // random mix
      for (int k = 0; k < 300; k++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 80)      press(4'($urandom_range(0, 15)), 1'b1);
         else if (r < 87) finish();
         else if (r < 97) set_load(~load_en);
         else             do_reset();
      end

      tick(4);
      chk("exp_left", 32'(exp_data_q.size()), 32'd0);
      chk("wr_count", 32'(act_writes), 32'(exp_writes));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The pipeline only ever reads instr_mem.
- Lets an operator key a program into instr_mem one hex nibble at a time, from the toggle switches and debounced pushbuttons.
- Assembles 8 nibbles into a 32-bit word, issues a one-cycle write, and advances a word address.
- Holds the CPU in reset (cpu_hold) for the whole load session. Sits between the debounce outputs and the instr_mem write port.

Parameters:
- ADDR_W, 7, byte-address width of wr_addr. Word index is ADDR_W-2 bits.
- MAX_WORDS, 32, words accepted before auto-finish. Must be ≤ 2^(ADDR_W-2).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- load_en  in  1  level; high requests a load session (SW-driven).
- nibble  in  4  hex digit to append (SW-driven).
- key_nibble  in  1  debounced level; each rising edge appends nibble.
- key_finish  in  1  debounced level; rising edge ends the session.
- wr_en  out  1  one-cycle write strobe to instr_mem.
- wr_addr  out  ADDR_W  byte address = {word_idx, 2'b00}.
- wr_data  out  32  word being written.
- cpu_hold  out  1  high whenever state != IDLE; ORed into the CPU reset by the top level.
- preview  out  32  current shift register, for LCD/hex display.
- nib_cnt  out  3  nibbles entered in the current word (0-7).
- word_cnt  out  ADDR_W-1  words written this session (0..MAX_WORDS).

Behaviour:
- Reset: state=IDLE. wr_en=0, wr_addr=0, wr_data=0, preview=0, nib_cnt=0, word_cnt=0, cpu_hold=0.
- Edge detect: key_nibble_q and key_finish_q reset to 1, so a key held through reset is not counted.
  - nib_edge = key_nibble & ~key_nibble_q.
  - fin_edge = key_finish & ~key_finish_q.
  - Edges are seen 1 cycle after the input rises.
- States: IDLE, ENTRY, WRITE, DONE.
- IDLE:
  - load_en=1 → ENTRY next cycle.
  - Same cycle: clear shift, nib_cnt, word_idx and word_cnt. cpu_hold rises with the ENTRY state.
- ENTRY, in priority order:
  - load_en=0 → IDLE. The partial word is discarded and no write occurs.
  - fin_edge → DONE. The partial word is discarded. A nib_edge in the same cycle is ignored.
  - nib_edge → shift <= {shift[27:0], nibble} (MSB-first entry).
    - nib_cnt 7 → WRITE, with nib_cnt wrapping to 0.
    - Otherwise nib_cnt+1.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_data=shift, wr_addr={word_idx,2'b00}. wr_data/wr_addr are registered and valid in the same cycle as wr_en.
  - On exit: word_cnt+1, word_idx+1, shift cleared.
  - Next state: word_cnt+1 == MAX_WORDS → DONE; else load_en=1 → ENTRY; else → IDLE. The write always completes even if load_en has dropped.
- DONE:
  - wr_en=0 and key edges ignored.
  - Stays in DONE until load_en=0, then → IDLE. cpu_hold drops on the IDLE cycle.
- wr_en is 0 in every state except WRITE. Writes occur at most once per WRITE entry.
- word_idx never wraps within a session, because MAX_WORDS caps it.
- preview = shift, continuously.
- Synchronous reset in any state: immediate return to reset values. A pending write is dropped (wr_en=0 that cycle).

Test Plan:
1. Reset, load_en=1, then 8 nibble presses with nibble=1..8 → one wr_en pulse, wr_data=0x12345678, wr_addr=0x00, word_cnt=1. cpu_hold=1 throughout.
2. Continue with nibbles A,B,C,D,E,F,0,9 → wr_data=0xABCDEF09, wr_addr=0x04, word_cnt=2, nib_cnt back to 0.
3. Enter 32 full words → 32 pulses at addresses 0x00..0x7C, state DONE, word_cnt=32. Further presses produce no wr_en. Dropping load_en → cpu_hold=0 next cycle.
4. Enter 5 nibbles, then drop load_en → no wr_en, IDLE, cpu_hold=0, nib_cnt=0. Reassert load_en → word_cnt=0, addr restarts at 0x00.
5. key_nibble held high across reset release → no nibble counted. Then key_nibble and key_finish rise in the same cycle during ENTRY → DONE, nib_cnt unchanged, no write.
6. Assert reset in the cycle before WRITE (7 nibbles entered, 8th edge pending) → no wr_en, all outputs at reset values next cycle.
